// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Two-requester round-robin arbiter and sequencer in front of one
//   single-port memory with a 1-cycle registered read. Each accepted command
//   is registered onto mem_we/mem_addr/mem_din; the memory samples it on the
//   following edge. The matching response strobe fires the cycle after that,
//   with rsp_rdata taken straight from mem_dout.
//
//   Optional feature macro: MEM_ARB_INIT_EN
//     When defined, after reset the block sweeps zeros into every address
//     (one write per cycle) before accepting commands; init_busy is high
//     during the sweep. When undefined, init_busy is tied 0.
//
// Ports
//   clk, rst                        clock (rising), async active-high reset
//   a_valid/a_ready/a_we/a_addr/a_wdata   requester A command handshake
//   b_valid/b_ready/b_we/b_addr/b_wdata   requester B command handshake
//   a_rsp_valid, b_rsp_valid        1-cycle response strobes
//   rsp_rdata                       shared response data (= mem_dout)
//   mem_we, mem_addr, mem_din       registered command to the memory
//   mem_dout                        read data from the memory
//   init_busy                       init sweep in progress
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_valid,
  output logic                  a_ready,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_rsp_valid,
  input  logic                  b_valid,
  output logic                  b_ready,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  init_busy
);

  logic       run;
  logic       last_grant_b;  // 1 = B won the most recent handshake
  logic       grant_a, grant_b;
  // Response tag: stage 0 follows the command register, stage 1 follows the
  // memory's output register. id = 1 routes the strobe to B.
  logic [1:0] vld_pipe;
  logic [1:0] id_pipe;

`ifdef MEM_ARB_INIT_EN
  typedef enum logic [0:0] {S_INIT, S_RUN} state_t;
  state_t                state;
  logic [ADDR_WIDTH-1:0] init_cnt;

  assign run       = (state == S_RUN);
  assign init_busy = (state == S_INIT);
`else
  assign run       = 1'b1;
  assign init_busy = 1'b0;
`endif

  // rst gates the grants so ready reads 0 while reset is held.
  assign grant_a = run & ~rst & a_valid & (~b_valid | last_grant_b);
  assign grant_b = run & ~rst & b_valid & ~grant_a;
  assign a_ready = grant_a;
  assign b_ready = grant_b;

  assign a_rsp_valid = vld_pipe[1] & ~id_pipe[1];
  assign b_rsp_valid = vld_pipe[1] &  id_pipe[1];
  assign rsp_rdata   = mem_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_din      <= '0;
      vld_pipe     <= '0;
      id_pipe      <= '0;
      last_grant_b <= 1'b1;
`ifdef MEM_ARB_INIT_EN
      state        <= S_INIT;
      init_cnt     <= '0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[0], grant_a | grant_b};
      id_pipe  <= {id_pipe[0], grant_b};
      if (grant_a | grant_b) last_grant_b <= grant_b;
`ifdef MEM_ARB_INIT_EN
      if (state == S_INIT) begin
        mem_we   <= 1'b1;
        mem_addr <= init_cnt;
        mem_din  <= '0;
        init_cnt <= init_cnt + 1'b1;
        // Leave on the edge that issues the last address so commands can
        // follow the final sweep write with no bubble.
        if (&init_cnt) state <= S_RUN;
      end else
`endif
      if (grant_a) begin
        mem_we   <= a_we;
        mem_addr <= a_addr;
        mem_din  <= a_wdata;
      end else if (grant_b) begin
        mem_we   <= b_we;
        mem_addr <= b_addr;
        mem_din  <= b_wdata;
      end else begin
        mem_we   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter with a behavioural single-port
// memory (read-before-write, 1-cycle registered dout).
module tb_mem_port_arbiter;
  localparam int DW = 8;
  localparam int AW = 4;
`ifdef MEM_ARB_INIT_EN
  localparam bit INIT = 1'b1;
`else
  localparam bit INIT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          a_valid = 1'b0, a_we = 1'b0, b_valid = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wdata = '0, b_wdata = '0;
  logic          a_ready, b_ready, a_rsp_valid, b_rsp_valid, mem_we, init_busy;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din, rsp_rdata;
  logic [DW-1:0] mem_dout = '0;

  mem_port_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
    .a_wdata(a_wdata), .a_rsp_valid(a_rsp_valid),
    .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
    .b_wdata(b_wdata), .b_rsp_valid(b_rsp_valid),
    .rsp_rdata(rsp_rdata), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .init_busy(init_busy)
  );

  always #5 clk = ~clk;

  // Memory model; filled once on the first edge. With the sweep enabled the
  // fill is non-zero so only the sweep can make unwritten reads return 0.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          filled = 1'b0;
  always @(posedge clk) begin
    if (!filled) begin
      for (int i = 0; i < (1<<AW); i++) mem[i] <= INIT ? 8'hEE : 8'h00;
      filled <= 1'b1;
    end else begin
      mem_dout <= mem[mem_addr];
      if (mem_we) mem[mem_addr] <= mem_din;
    end
  end

  typedef struct packed { logic id; logic [DW-1:0] d; } exp_t;
  exp_t q[$];
  int vecs = 0, errs = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: pop one expectation per response strobe.
  always @(negedge clk) begin
    if (!rst && (a_rsp_valid || b_rsp_valid)) begin
      if (a_rsp_valid && b_rsp_valid) chk("rsp_both", 2'b11, 2'b01);
      else if (q.size() == 0) chk("rsp_unexpected", {b_rsp_valid, rsp_rdata}, 32'hFFFF);
      else begin
        exp_t e;
        e = q.pop_front();
        chk("rsp_id", {31'd0, b_rsp_valid}, {31'd0, e.id});
        chk("rsp_data", {24'd0, rsp_rdata}, {24'd0, e.d});
      end
    end
  end

  // One stimulus cycle. g: 0 none, 1 A, 2 B, 3 A granted but no response
  // expected (command killed by reset).
  task automatic cyc(input bit av, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input bit bv, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                     input int g, input logic [DW-1:0] ed);
    @(negedge clk);
    a_valid = av; a_we = aw; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd;
    #1;
    chk("ready", {30'd0, a_ready, b_ready},
        (g == 1 || g == 3) ? 32'd2 : (g == 2) ? 32'd1 : 32'd0);
    if (g == 1 || g == 2) q.push_back({g == 2, ed});
  endtask

  task automatic wait_init();
`ifdef MEM_ARB_INIT_EN
    int busy_cnt = 0;
    int nxt = 0;
    bit done = 0;
    a_valid = 1'b1; a_we = 1'b0; a_addr = 4'd7;
    for (int i = 0; i < 40 && !done; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (mem_we) begin
        chk("init_addr", {28'd0, mem_addr}, nxt);
        nxt++;
      end
      if (init_busy) begin
        busy_cnt++;
        chk("init_rdy", {31'd0, a_ready}, 32'd0);
      end else begin
        chk("post_init_rdy", {31'd0, a_ready}, 32'd1);
        a_valid = 1'b0;
        done = 1;
      end
    end
    chk("init_busy_cycles", busy_cnt, 16);
    chk("init_writes", nxt, 16);
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_valid = 1'b1; b_valid = 1'b1;
    #1;
    chk("rst_a_ready", {31'd0, a_ready}, 0);
    chk("rst_b_ready", {31'd0, b_ready}, 0);
    chk("rst_rsp", {30'd0, a_rsp_valid, b_rsp_valid}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_mem_addr", {28'd0, mem_addr}, 0);
    chk("rst_mem_din", {24'd0, mem_din}, 0);
    chk("rst_init_busy", {31'd0, init_busy}, {31'd0, INIT});
    repeat (2) @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0; rst = 1'b0;
    wait_init();
  endtask

  initial begin
    do_reset();
    // Test 1: A write 0x3C @5 (old data 0), then read back.
    cyc(1,1,5,8'h3C, 0,0,0,0, 1, 8'h00);
    cyc(1,0,5,8'h00, 0,0,0,0, 1, 8'h3C);
    cyc(0,0,0,0,     0,0,0,0, 0, 0);
    // Test 4: handshake then reset before the memory samples it.
    cyc(1,1,3,8'h77, 0,0,0,0, 3, 0);
    do_reset();
    // Test 2: both held; A wins first after reset, then alternation.
    cyc(1,1,1,8'hA1, 1,1,2,8'hB2, 1, 8'h00);
    cyc(1,0,2,8'h00, 1,1,2,8'hB2, 2, 8'h00);
    cyc(1,0,2,8'h00, 1,0,1,8'h00, 1, 8'hB2);
    cyc(1,0,3,8'h00, 1,0,1,8'h00, 2, 8'hA1);
    cyc(1,0,3,8'h00, 0,0,0,0,     1, 8'h00);  // aborted write never landed
    // Test 3: write/read/write same address back to back.
    cyc(1,1,2,8'h11, 0,0,0,0, 1, 8'hB2);
    cyc(0,0,0,0,     1,0,2,0, 2, 8'h11);
    cyc(0,0,0,0,     1,1,2,8'h22, 2, 8'h11);
    cyc(1,0,2,0,     0,0,0,0, 1, 8'h22);
    // Contest after an A grant goes to B, then held A proceeds.
    cyc(1,0,5,0,     1,0,1,0, 2, 8'hA1);
    cyc(1,0,5,0,     0,0,0,0, 1, INIT ? 8'h00 : 8'h3C);
    repeat (3) cyc(0,0,0,0, 0,0,0,0, 0, 0);
    #1;
    chk("idle_mem_we", {31'd0, mem_we}, 0);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      vecs++; errs++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
